// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO UART transmitter:
// register offsets, STATUS bit positions and FSM encodings.
package mmio_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_W   = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output.
// A push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, 8N1 shifter,
// STATUS with sticky overflow, programmable bit divider.
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter int DEFAULT_DIV = 434,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ena,
   input  logic [3:0]  MemWrite_EN,
   input  logic [31:0] MemAddr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        uart_txd,
   output logic        irq_tx_empty
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    sel;
   logic          push_req;
   logic          pop;
   logic [7:0]    fifo_dout;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          ovf_q;
   logic          ovf_set;
   logic          ovf_clr;
   logic [15:0]   baud_div;
   logic [31:0]   status;
   logic [31:0]   rd_mux;

   tx_state_t     state;
   tx_state_t     state_n;
   logic [15:0]   cnt;
   logic [15:0]   div_q;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_n;
   logic [7:0]    data_q;
   logic          txd_q;
   logic          txd_n;
   logic          tick;
   logic          unused;

   assign unused = ^{MemAddr[31:4], MemAddr[1:0],
                     MemWrite_EN[3:2], WriteData[31:16]};

   assign sel      = MemAddr[3:2];
   assign push_req = ena && (sel == REG_TXDATA)
                   && MemWrite_EN[0];
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = ena && (sel == REG_STATUS)
                   && MemWrite_EN[0] && WriteData[3];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .din   (WriteData[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // STATUS word and load-data selection.
   always_comb begin
      status = '0;
      status[ST_BUSY]  = (state != IDLE);
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF]   = ovf_q;
      status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
      rd_mux = '0;
      case (sel)
         REG_STATUS: rd_mux = status;
         REG_BAUD:   rd_mux = {16'h0, baud_div};
         default:    rd_mux = '0;
      endcase
   end

   // Register file: divider, sticky overflow, load data.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_div <= 16'(DEFAULT_DIV);
         ovf_q    <= 1'b0;
         ReadData <= '0;
      end else begin
         if (ena && sel == REG_BAUD) begin
            if (MemWrite_EN[0]) baud_div[7:0]  <= WriteData[7:0];
            if (MemWrite_EN[1]) baud_div[15:8] <= WriteData[15:8];
         end
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
         if (ena) ReadData <= rd_mux;
      end
   end

   assign tick = (cnt == div_q - 16'd1);

   // Frame sequencing; txd is computed for the next state.
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      bit_n   = bit_idx;
      txd_n   = 1'b1;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (tick) begin
               state_n = DATA;
               bit_n   = 3'd0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx == 3'd7) state_n = STOP;
               else bit_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (tick) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
      endcase
      unique case (state_n)
         IDLE:  txd_n = 1'b1;
         START: txd_n = 1'b0;
         DATA:  txd_n = data_q[bit_n];
         STOP:  txd_n = 1'b1;
      endcase
   end

   // Shifter state, bit timer and registered serial output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         div_q   <= 16'd1;
         bit_idx <= '0;
         data_q  <= '0;
         txd_q   <= 1'b1;
      end else begin
         state   <= state_n;
         bit_idx <= bit_n;
         txd_q   <= txd_n;
         if (pop) begin
            data_q <= fifo_dout;
            div_q  <= (baud_div == 16'd0) ? 16'd1 : baud_div;
         end
         if (pop || tick || state == IDLE) cnt <= '0;
         else cnt <= cnt + 16'd1;
      end
   end

   assign uart_txd     = txd_q;
   assign irq_tx_empty = empty && (state == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected bytes are queued
// at issue time and a line monitor checks every serial frame.
module tb_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        ena;
   logic [3:0]  MemWrite_EN;
   logic [31:0] MemAddr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        uart_txd;
   logic        irq_tx_empty;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int baud_model = 434;
   bit in_frame = 0;
   logic [7:0] exp_q[$];
   int starts[$];

   logic [7:0] m_b;
   int m_d, m_k, m_i;
   bit m_bad, m_abort;
   logic m_e, m_got;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mmio_uart_tx dut (
      .clk          (clk),
      .reset        (reset),
      .ena          (ena),
      .MemWrite_EN  (MemWrite_EN),
      .MemAddr      (MemAddr),
      .WriteData    (WriteData),
      .ReadData     (ReadData),
      .uart_txd     (uart_txd),
      .irq_tx_empty (irq_tx_empty)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h",
                  name, act, exp);
      end
   endtask

   // Line monitor: each start bit consumes one expected byte
   // and the whole frame is compared cycle by cycle.
   always begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start at cycle %0d", cyc);
            while (uart_txd === 1'b0 && !reset) @(negedge clk);
         end else begin
            m_b = exp_q.pop_front();
            m_d = (baud_model == 0) ? 1 : baud_model;
            in_frame = 1;
            starts.push_back(cyc);
            m_bad = 0;
            m_abort = 0;
            m_i = 0;
            m_got = 1'b0;
            for (int i = 0; i < 10 * m_d; i++) begin
               if (i > 0) @(negedge clk);
               if (reset) begin
                  m_abort = 1;
                  break;
               end
               m_k = i / m_d;
               if (m_k == 0) m_e = 1'b0;
               else if (m_k == 9) m_e = 1'b1;
               else m_e = m_b[m_k-1];
               if (uart_txd !== m_e && !m_bad) begin
                  m_bad = 1;
                  m_i = i;
                  m_got = uart_txd;
               end
            end
            if (!m_abort) begin
               checks++;
               if (m_bad) begin
                  errors++;
                  $display("FAIL frame %02h div %0d: cycle %0d got %0b, required %0b",
                           m_b, m_d, m_i, m_got, !m_got);
               end
            end
            in_frame = 0;
         end
      end
   end

   task automatic bus_wr(input logic [1:0] a,
                         input logic [3:0] be,
                         input logic [31:0] d);
      @(posedge clk);
      #1;
      ena = 1'b1;
      MemAddr = {28'h0, a, 2'b00};
      MemWrite_EN = be;
      WriteData = d;
      @(posedge clk);
      #1;
      ena = 1'b0;
      MemWrite_EN = 4'h0;
   endtask

   task automatic bus_rd(input logic [1:0] a,
                         output logic [31:0] d);
      @(posedge clk);
      #1;
      ena = 1'b1;
      MemAddr = {28'h0, a, 2'b00};
      MemWrite_EN = 4'h0;
      @(posedge clk);
      #1;
      ena = 1'b0;
      d = ReadData;
   endtask

   task automatic rd_check(input string name,
                           input logic [1:0] a,
                           input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(name, d, exp);
   endtask

   task automatic set_baud(input int d);
      bus_wr(2'd2, 4'b0011, 32'(d));
      baud_model = d;
   endtask

   task automatic send(input logic [7:0] b);
      exp_q.push_back(b);
      bus_wr(2'd0, 4'b0001, {24'hFFFFFF, b});
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < max) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, %0d bytes pending",
                  name, n, exp_q.size());
      end
   endtask

   task automatic wait_start(input string name, input int max);
      int n = 0;
      while (!in_frame && n < max) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL %s: no start bit within %0d cycles", name, n);
      end
   endtask

   initial begin
      logic [31:0] d;
      int st;
      int n;
      reset = 1'b1;
      ena = 1'b0;
      MemWrite_EN = 4'h0;
      MemAddr = '0;
      WriteData = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("reset_txd", 32'(uart_txd), 32'd1);
      check("reset_irq", 32'(irq_tx_empty), 32'd1);
      check("reset_rdata", ReadData, 32'd0);

      bus_rd(2'd1, d);
      check("status_n1", d, 32'h4);
      @(posedge clk);
      #1;
      check("status_held_n2", ReadData, 32'h4);
      rd_check("baud_reset", 2'd2, 32'd434);

      bus_wr(2'd2, 4'b1111, 32'hDEAD1234);
      rd_check("baud_full", 2'd2, 32'h1234);
      bus_wr(2'd2, 4'b0010, 32'hFFFFAB77);
      rd_check("baud_lane1", 2'd2, 32'hAB34);
      bus_wr(2'd3, 4'b1111, 32'hFFFFFFFF);
      rd_check("reserved", 2'd3, 32'h0);
      bus_wr(2'd0, 4'b1110, 32'h5A5A5A5A);
      repeat (4) @(posedge clk);
      #1;
      check("tx_no_strobe0", 32'(irq_tx_empty), 32'd1);

      set_baud(4);
      send(8'h55);
      wait_start("f55_start", 20);
      check("f55_irq_busy", 32'(irq_tx_empty), 32'd0);
      wait_idle("f55", 200);
      #1;
      check("f55_irq_done", 32'(irq_tx_empty), 32'd1);

      starts.delete();
      set_baud(2);
      send(8'hA1);
      send(8'hB2);
      wait_idle("b2b", 200);
      check("b2b_frames", 32'(starts.size()), 32'd2);
      if (starts.size() == 2)
         check("b2b_gap", 32'(starts[1] - starts[0]), 32'd20);

      starts.delete();
      set_baud(4);
      send(8'h3C);
      send(8'hC3);
      wait_start("chg_start", 20);
      repeat (15) @(posedge clk);
      set_baud(8);
      wait_idle("chg", 400);
      check("chg_frames", 32'(starts.size()), 32'd2);
      if (starts.size() == 2)
         check("chg_first_len", 32'(starts[1] - starts[0]), 32'd40);

      set_baud(16);
      send(8'h11);
      wait_start("ovf_start", 20);
      for (int i = 0; i < 17; i++) begin
         d = $urandom;
         if (i < 16) exp_q.push_back(d[7:0]);
         bus_wr(2'd0, 4'b0001, d);
      end
      st = (16 << 4) | 8 | 2 | 1;
      rd_check("ovf_status", 2'd1, 32'(st));
      bus_wr(2'd1, 4'b0010, 32'h8);
      rd_check("ovf_no_strobe", 2'd1, 32'(st));
      bus_wr(2'd1, 4'b0001, 32'h8);
      rd_check("ovf_w1c", 2'd1, 32'(st & ~8));
      wait_idle("ovf_drain", 17 * 160 + 400);
      rd_check("ovf_drained", 2'd1, 32'h4);

      set_baud(0);
      send(8'h96);
      wait_idle("div0", 100);

      set_baud(4);
      send(8'h0F);
      wait_start("rst_start", 20);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_txd", 32'(uart_txd), 32'd1);
      reset = 1'b0;
      exp_q.delete();
      baud_model = 434;
      rd_check("rst_status", 2'd1, 32'h4);
      rd_check("rst_baud", 2'd2, 32'd434);

      for (int it = 0; it < 15; it++) begin
         set_baud($urandom_range(0, 5));
         n = $urandom_range(1, 6);
         for (int j = 0; j < n; j++) begin
            d = $urandom;
            send(d[7:0]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
         end
         wait_idle("rand", n * 60 + 200);
      end
      #1;
      check("final_irq", 32'(irq_tx_empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
